// File: rtl/vx_commit_timeit.sv
// vx_commit_timeit: merges the per-unit commit fires into one registered
// valid/commit_size pair for the CSR unit, and runs the timeit window FSM.
// The FSM opens a window when a warp commits the start PC, counts cycles,
// and closes it when that same warp commits the end PC.
module vx_commit_timeit #(
    parameter int NUM_UNITS   = 6,
    parameter int NUM_THREADS = 4,
    parameter int NW_BITS     = 2,
    parameter int CS_W        = $clog2(NUM_UNITS*NUM_THREADS+1)
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_UNITS-1:0]             cmt_valid,
    input  logic [NUM_UNITS*NUM_THREADS-1:0] cmt_tmask,
    input  logic [NUM_UNITS*NW_BITS-1:0]     cmt_wid,
    input  logic [NUM_UNITS*32-1:0]          cmt_pc,
    input  logic                             timeit_enable,
    input  logic [31:0]                      timeit_start_addr,
    input  logic [31:0]                      timeit_end_addr,
    output logic                             valid,
    output logic [CS_W-1:0]                  commit_size,
    output logic [NW_BITS-1:0]               timeit_active,
    output logic                             timeit_busy,
    output logic [31:0]                      timeit_cycles,
    output logic                             timeit_done
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]         state;
    logic [CS_W-1:0]    size_sum;
    logic               start_hit;
    logic [NW_BITS-1:0] start_wid;
    logic               end_hit;

    // Thread count of this cycle's commits: popcount of each firing unit's mask.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
        size_sum = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (cmt_valid[i]) begin
                for (int t = 0; t < NUM_THREADS; t++) begin
                    size_sum = size_sum + CS_W'(cmt_tmask[i*NUM_THREADS + t]);
                end
            end
        end
    end

    // Start/end matching; scanning from the top down leaves the lowest-index
    // start match as the winner.
    always_comb begin
        start_hit = 1'b0;
        start_wid = '0;
        end_hit   = 1'b0;
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            if (cmt_valid[i] && timeit_enable &&
                cmt_pc[i*32 +: 32] == timeit_start_addr) begin
                start_hit = 1'b1;
                start_wid = cmt_wid[i*NW_BITS +: NW_BITS];
            end
            if (cmt_valid[i] && cmt_pc[i*32 +: 32] == timeit_end_addr &&
                cmt_wid[i*NW_BITS +: NW_BITS] == timeit_active) begin
                end_hit = 1'b1;
            end
        end
    end

    // Registered commit outputs and the IDLE/RUN timeit window FSM.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid         <= 1'b0;
            commit_size   <= '0;
            timeit_active <= '0;
            timeit_busy   <= 1'b0;
            timeit_cycles <= '0;
            timeit_done   <= 1'b0;
            state         <= ST_IDLE;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            valid       <= |cmt_valid;
            commit_size <= size_sum;
            timeit_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // End matches are ignored while idle, even in the arming cycle.
                    if (start_hit) begin
                        timeit_active <= start_wid;
                        timeit_cycles <= '0;
                        timeit_busy   <= 1'b1;
                        state         <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // The count advances on the closing/aborting cycle as well.
                    if (timeit_cycles != 32'hFFFF_FFFF) begin
                        timeit_cycles <= timeit_cycles + 32'd1;
                    end
                    if (end_hit) begin
                        timeit_done <= 1'b1;
                        timeit_busy <= 1'b0;
                        state       <= ST_IDLE;
                    end else if (!timeit_enable) begin
                        timeit_busy <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vx_commit_timeit.sv
// Directed testbench for vx_commit_timeit: reset, aggregation, timeit window,
// tie/ignore rules, enable abort, start==end and reset mid-window.
module tb_vx_commit_timeit;

    localparam int NU   = 6;
    localparam int NT   = 4;
    localparam int NW   = 2;
    localparam int CS_W = $clog2(NU*NT+1);

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NU-1:0]     cmt_valid;
    logic [NU*NT-1:0]  cmt_tmask;
    logic [NU*NW-1:0]  cmt_wid;
    logic [NU*32-1:0]  cmt_pc;
    logic              timeit_enable;
    logic [31:0]       timeit_start_addr;
    logic [31:0]       timeit_end_addr;
    logic              valid;
    logic [CS_W-1:0]   commit_size;
    logic [NW-1:0]     timeit_active;
    logic              timeit_busy;
    logic [31:0]       timeit_cycles;
    logic              timeit_done;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] START_PC = 32'h8000_0100;
    localparam logic [31:0] END_PC   = 32'h8000_0200;

    vx_commit_timeit #(
        .NUM_UNITS(NU), .NUM_THREADS(NT), .NW_BITS(NW), .CS_W(CS_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cmt_valid(cmt_valid), .cmt_tmask(cmt_tmask), .cmt_wid(cmt_wid), .cmt_pc(cmt_pc),
        .timeit_enable(timeit_enable), .timeit_start_addr(timeit_start_addr),
        .timeit_end_addr(timeit_end_addr),
        .valid(valid), .commit_size(commit_size), .timeit_active(timeit_active),
        .timeit_busy(timeit_busy), .timeit_cycles(timeit_cycles), .timeit_done(timeit_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic clear_units();
        cmt_valid = '0;
        cmt_tmask = '0;
        cmt_wid   = '0;
        cmt_pc    = '0;
    endtask

    task automatic set_unit(input int i, input logic [NT-1:0] mask,
                            input logic [NW-1:0] wid, input logic [31:0] pc);
        cmt_valid[i]          = 1'b1;
        cmt_tmask[i*NT +: NT] = mask;
        cmt_wid[i*NW +: NW]   = wid;
        cmt_pc[i*32 +: 32]    = pc;
    endtask

    task automatic check_timeit(input string tag, input logic busy, input logic [NW-1:0] act,
                                input logic [31:0] cyc, input logic done);
        check({tag, ".busy"},   32'(timeit_busy),   32'(busy));
        check({tag, ".active"}, 32'(timeit_active), 32'(act));
        check({tag, ".cycles"}, timeit_cycles,      cyc);
        check({tag, ".done"},   32'(timeit_done),   32'(done));
    endtask

    initial begin
        // Reset with every input driven active.
        reset_n           = 1'b0;
        cmt_valid         = '1;
        cmt_tmask         = '1;
        cmt_wid           = '1;
        for (int i = 0; i < NU; i++) cmt_pc[i*32 +: 32] = START_PC;
        timeit_enable     = 1'b1;
        timeit_start_addr = START_PC;
        timeit_end_addr   = END_PC;
        steps(2);
        check("rst.valid", 32'(valid), 32'd0);
        check("rst.size",  32'(commit_size), 32'd0);
        check_timeit("rst", 1'b0, 2'd0, 32'd0, 1'b0);

        // Aggregation: units 0,2,5 fire with 4+2+1 threads; unit 1 masked off.
        reset_n       = 1'b1;
        timeit_enable = 1'b0;
        clear_units();
        set_unit(0, 4'b1111, 2'd0, 32'h0);
        set_unit(2, 4'b0011, 2'd0, 32'h0);
        set_unit(5, 4'b0001, 2'd0, 32'h0);
        cmt_tmask[1*NT +: NT] = 4'b1111;
        step();
        check("agg.valid", 32'(valid), 32'd1);
        check("agg.size",  32'(commit_size), 32'd7);

        clear_units();
        cmt_tmask = '1;
        step();
        check("idle.valid", 32'(valid), 32'd0);
        check("idle.size",  32'(commit_size), 32'd0);

        clear_units();
        set_unit(3, 4'b0000, 2'd0, 32'h0);
        step();
        check("zmask.valid", 32'(valid), 32'd1);
        check("zmask.size",  32'(commit_size), 32'd0);

        cmt_valid = '1;
        cmt_tmask = '1;
        step();
        check("full.size", 32'(commit_size), 32'd24);

        // Window: warp 2 opens (same-cycle end match is ignored in IDLE).
        timeit_enable = 1'b1;
        clear_units();
        set_unit(0, 4'b0001, 2'd2, START_PC);
        set_unit(1, 4'b0001, 2'd2, END_PC);
        step();
        check_timeit("win.open", 1'b1, 2'd2, 32'd0, 1'b0);
        clear_units();
        steps(4);
        check("win.c4", timeit_cycles, 32'd4);
        set_unit(0, 4'b0001, 2'd1, END_PC);   // other warp: ignored
        step();
        check_timeit("win.other", 1'b1, 2'd2, 32'd5, 1'b0);
        clear_units();
        steps(4);
        set_unit(3, 4'b0001, 2'd2, END_PC);
        step();
        check_timeit("win.close", 1'b0, 2'd2, 32'd10, 1'b1);
        clear_units();
        step();
        check_timeit("win.after", 1'b0, 2'd2, 32'd10, 1'b0);

        // start==end: warp 1 opens, closes on its next commit (earliest close).
        timeit_end_addr = START_PC;
        set_unit(4, 4'b0001, 2'd1, START_PC);
        step();
        check_timeit("same.open", 1'b1, 2'd1, 32'd0, 1'b0);
        step();
        check_timeit("same.close", 1'b0, 2'd1, 32'd1, 1'b1);
        clear_units();
        timeit_end_addr = END_PC;
        step();
        check_timeit("same.after", 1'b0, 2'd1, 32'd1, 1'b0);

        // Tie: units 1 (wid 3) and 3 (wid 0) both start-match; unit 1 wins.
        set_unit(1, 4'b0001, 2'd3, START_PC);
        set_unit(3, 4'b0001, 2'd0, START_PC);
        step();
        check_timeit("tie.open", 1'b1, 2'd3, 32'd0, 1'b0);
        clear_units();
        steps(2);
        set_unit(0, 4'b0001, 2'd1, START_PC); // re-arm attempt ignored
        step();
        check_timeit("tie.rearm", 1'b1, 2'd3, 32'd3, 1'b0);
        clear_units();
        steps(2);
        check("abort.c5", timeit_cycles, 32'd5);

        // Abort: enable drops at cycles=5.
        timeit_enable = 1'b0;
        step();
        check_timeit("abort", 1'b0, 2'd3, 32'd6, 1'b0);
        set_unit(2, 4'b0001, 2'd3, END_PC);
        step();
        check_timeit("abort.end", 1'b0, 2'd3, 32'd6, 1'b0);
        clear_units();

        // Reset mid-window at cycles=40.
        timeit_enable = 1'b1;
        set_unit(5, 4'b0001, 2'd1, START_PC);
        step();
        clear_units();
        steps(40);
        check_timeit("midrst.pre", 1'b1, 2'd1, 32'd40, 1'b0);
        reset_n = 1'b0;
        step();
        check_timeit("midrst", 1'b0, 2'd0, 32'd0, 1'b0);
        reset_n = 1'b1;
        step();
        check_timeit("midrst.after", 1'b0, 2'd0, 32'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
